// File: rtl/tl_arb_pkg.sv
// Shared definitions for the transaction-layer virtual-channel arbiter.
package tl_arb_pkg;

  localparam int unsigned DEF_N_SRC  = 4;
  localparam int unsigned DEF_DATA_W = 10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_RUN   = 2'b01,
    ARB_DRAIN = 2'b10
  } arb_state_e;

endpackage

// File: rtl/tl_vc_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N_SRC.
module rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1, ptr+2, ... ptr+N_SRC; index arithmetic wraps because N_SRC is a power of 2
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = N_SRC'(any) << gnt_idx;
  end

endmodule

// File: rtl/tl_vc_rr_arbiter.sv
// Round-robin arbiter moving words from N_SRC source FIFOs into one destination FIFO.
module tl_vc_rr_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned N_SRC  = DEF_N_SRC,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_SRC-1:0]        src_empty,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_pop,
  input  logic                    dst_almost_full,
  output logic                    dst_push,
  output logic [DATA_W-1:0]       dst_data,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_SRC-1:0]  last_pop;
  logic              issue;

  // Stage 1: pop issued last cycle, source read data becomes valid now
  logic              s1_valid;
  logic [IDX_W-1:0]  s1_idx;
  logic [DATA_W-1:0] s1_word;

  // Stage 2: word presented to the destination FIFO
  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;

  logic [N_SRC-1:0]  req;
  logic [N_SRC-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  // A source popped last cycle still shows a stale empty flag, so it sits out one cycle
  assign req = ~src_empty & ~last_pop;

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and pop issue; enable and almost_full both gate this cycle's decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    src_pop   = '0;
    grant_idx = '0;
    case (state)
      ARB_IDLE: begin
        if (enable) state_nxt = ARB_RUN;
      end
      ARB_RUN: begin
        if (!enable) begin
          state_nxt = ARB_DRAIN;
        end else if (!dst_almost_full && pick_any) begin
          issue     = 1'b1;
          src_pop   = pick_gnt;
          grant_idx = pick_idx;
        end
      end
      ARB_DRAIN: begin
        // Only stage 1 can hold a word that still needs a future push cycle
        if (enable)        state_nxt = ARB_RUN;
        else if (!s1_valid) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Round-robin pointer and previous-pop mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= IDX_W'(N_SRC - 1);
      last_pop <= '0;
    end else begin
      if (issue) rr_ptr <= pick_idx;
      last_pop <= src_pop;
    end
  end

  assign s1_word = src_data[s1_idx*DATA_W +: DATA_W];

  // Two-stage valid/index/data pipeline from pop to destination push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) s1_idx <= pick_idx;
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_word;
    end
  end

  assign dst_push = s2_valid;
  assign dst_data = s2_data;
  assign busy     = (state != ARB_IDLE) | s1_valid | s2_valid;

endmodule

// File: tb/tb_tl_vc_rr_arbiter.sv
// Scoreboard bench for tl_vc_rr_arbiter with a cycle-level reference model.
module tb_tl_vc_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    src_empty;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_pop;
  logic            dst_almost_full;
  logic            dst_push;
  logic [DW-1:0]   dst_data;
  logic [IW-1:0]   grant_idx;
  logic            busy;

  tl_vc_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .src_pop         (src_pop),
    .dst_almost_full (dst_almost_full),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .grant_idx       (grant_idx),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFO contents (environment) and the model's own copy
  logic [DW-1:0] src_q   [N][$];
  logic [DW-1:0] model_q [N][$];

  typedef struct {
    logic [DW-1:0] word;
    int            due;
  } exp_t;
  exp_t sb[$];

  // Reference model state: mode 0=idle 1=run 2=drain
  int m_mode = 0;
  int m_rr   = N - 1;
  int m_last = -1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference model: predicts each cycle's pop from the arbitration rules, queues expected pushes
  initial forever begin
    int           win;
    int           idx;
    bit           pend;
    logic [N-1:0] exp_pop;
    @(negedge clk);
    if (reset) begin
      m_mode = 0;
      m_rr   = N - 1;
      m_last = -1;
      sb.delete();
    end else begin
      win = -1;
      if (m_mode == 1 && enable && !dst_almost_full) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_rr + k) % N;
          if (win < 0 && !src_empty[idx] && idx != m_last) win = idx;
        end
      end
      exp_pop = (win >= 0) ? (N'(1) << win) : '0;
      chk("src_pop", 32'(src_pop), 32'(exp_pop));
      if (win >= 0) chk("grant_idx", 32'(grant_idx), 32'(win));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      if (win >= 0) begin
        if (model_q[win].size() != 0) sb.push_back('{word: model_q[win].pop_front(), due: cyc + 2});
        m_rr = win;
      end
      m_last = win;
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: if (!enable) m_mode = 2;
        default: begin
          if (enable) m_mode = 1;
          else begin
            pend = 1'b0;
            foreach (sb[j]) if (sb[j].due > cyc) pend = 1'b1;
            if (!pend) m_mode = 0;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pushes or an expected push falls due
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset && (dst_push || (sb.size() != 0 && sb[0].due <= cyc))) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_push: got push data %0h expected no push at cycle %0d", dst_data, cyc);
      end else begin
        e = sb.pop_front();
        if (!dst_push || dst_data !== e.word || cyc != e.due) begin
          errors++;
          $display("FAIL dst_push: got push=%0b data=%0h at cycle %0d expected data %0h at cycle %0d",
                   dst_push, dst_data, cyc, e.word, e.due);
        end
      end
    end
  end

  logic [N-1:0] pop_s;

  task automatic update_empty();
    for (int i = 0; i < N; i++) src_empty[i] = (src_q[i].size() == 0);
  endtask

  // One clock: source FIFOs react to the DUT's pops, then inputs may change at +1
  task automatic tick();
    @(negedge clk);
    pop_s = src_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop_s[i] && src_q[i].size() != 0) src_data[i*DW +: DW] = src_q[i].pop_front();
    update_empty();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(int s, logic [DW-1:0] w);
    src_q[s].push_back(w);
    model_q[s].push_back(w);
    update_empty();
  endtask

  function automatic int total_left();
    int t = 0;
    for (int i = 0; i < N; i++) t += src_q[i].size();
    return t;
  endfunction

  task automatic drain_all();
    int guard = 0;
    while (total_left() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    chk("drain_timeout", 32'(total_left()), 32'd0);
    run(5);
  endtask

  initial begin
    int guard;
    reset           = 1'b1;
    enable          = 1'b0;
    dst_almost_full = 1'b0;
    src_empty       = '1;
    src_data        = '0;
    run(3);

    // Reset state
    chk("rst_src_pop",   32'(src_pop),   32'd0);
    chk("rst_dst_push",  32'(dst_push),  32'd0);
    chk("rst_dst_data",  32'(dst_data),  32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // Enabled with all sources empty: running but idle
    run(8);
    chk("empty_run_busy", 32'(busy), 32'd1);

    // All four sources loaded: 0,1,2,3,0,... one per cycle
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) load(i, DW'(1 + i + 16 * r));
    drain_all();

    // Lone source 2: popped every other cycle
    load(2, 10'h2A5);
    load(2, 10'h15A);
    load(2, 10'h3FF);
    run(14);

    // Back-pressure for 5 cycles while streaming
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < N; i++) load(i, DW'($urandom));
    run(3);
    dst_almost_full = 1'b1;
    run(5);
    dst_almost_full = 1'b0;
    drain_all();

    // Disable mid-stream: drain in-flight words then go idle
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < N; i++) load(i, DW'($urandom));
    run(3);
    enable = 1'b0;
    run(6);
    chk("drain_idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    drain_all();

    // Randomized traffic with enable and back-pressure toggling
    for (int c = 0; c < 400; c++) begin
      tick();
      if ($urandom_range(2, 0) == 0) load(int'($urandom_range(N - 1, 0)), DW'($urandom));
      if ($urandom_range(19, 0) == 0) enable = ~enable;
      dst_almost_full = ($urandom_range(3, 0) == 0);
    end
    enable          = 1'b1;
    dst_almost_full = 1'b0;
    drain_all();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a push is in progress
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < N; i++) load(i, DW'($urandom));
    guard = 0;
    while (!dst_push && guard < 30) begin
      tick();
      guard++;
    end
    chk("wait_push_seen", 32'(dst_push), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_push", 32'(dst_push), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    drain_all();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
